// File: rtl/cgp_node_sequencer_if.sv
// Bus between the CGP node sequencer, its genome memory and the shared node evaluator.
// The master side is the sequencer. The slave side is the genome store plus the node block.
interface cgp_node_sequencer_if #(
   parameter int ADDR_BIT    = 3,
   parameter int GENE_BIT    = 10,
   parameter int CHOICES_BIT = 9,
   parameter int SEL_BIT     = 4,
   parameter int FUNC_BIT    = 2
);
   logic                   gene_rd_en;
   logic [ADDR_BIT-1:0]    gene_addr;
   logic [GENE_BIT-1:0]    gene_data;
   logic [CHOICES_BIT-1:0] node_choices;
   logic [SEL_BIT-1:0]     node_sel0;
   logic [SEL_BIT-1:0]     node_sel1;
   logic [FUNC_BIT-1:0]    node_func;
   logic                   node_result;

   modport master (
      output gene_rd_en, gene_addr, node_choices, node_sel0, node_sel1, node_func,
      input  gene_data, node_result
   );

   modport slave (
      input  gene_rd_en, gene_addr, node_choices, node_sel0, node_sel1, node_func,
      output gene_data, node_result
   );
endinterface

// File: rtl/cgp_node_sequencer.sv
// Evaluates one CGP genome by stepping a shared combinational node block over all nodes in
// feed-forward order. Each node's result is written back into the choices vector.
module cgp_node_sequencer #(
   parameter int NUM_IN      = 4,
   parameter int NUM_NODES   = 5,
   parameter int CHOICES_BIT = 9,
   parameter int SEL_BIT     = 4,
   parameter int FUNC_BIT    = 2,
   parameter int ADDR_BIT    = 3,
   parameter int GENE_BIT    = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [NUM_IN-1:0]    in_bits,
   cgp_node_sequencer_if.master bus,
   output logic                 busy,
   output logic                 done,
   output logic                 result,
   output logic [NUM_NODES-1:0] values,
   output logic                 fwd_err
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EVAL, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [ADDR_BIT-1:0]  k_q, k_d;
   logic [NUM_IN-1:0]    in_q, in_d;
   logic [NUM_NODES-1:0] values_q, values_d;
   logic                 fwd_err_q, fwd_err_d;
   logic [SEL_BIT-1:0]   sel0_q, sel0_d, sel1_q, sel1_d;
   logic [FUNC_BIT-1:0]  func_q, func_d;

   logic [SEL_BIT-1:0]   gene_sel0, gene_sel1;
   logic [FUNC_BIT-1:0]  gene_func;
   logic [SEL_BIT:0]     fwd_limit;
   logic                 last_node;
   logic                 accept;

   // Gene layout is {func, sel1, sel0}.
   assign gene_sel0 = bus.gene_data[SEL_BIT-1:0];
   assign gene_sel1 = bus.gene_data[2*SEL_BIT-1:SEL_BIT];
   assign gene_func = bus.gene_data[GENE_BIT-1:2*SEL_BIT];

   assign last_node = (k_q == ADDR_BIT'(NUM_NODES - 1));
   assign fwd_limit = (SEL_BIT+1)'(NUM_IN) + (SEL_BIT+1)'(k_q);
   assign accept    = (state_q == S_IDLE) && start;

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_FETCH;
         S_FETCH: state_d = S_EVAL;
         S_EVAL:  state_d = last_node ? S_DONE : S_FETCH;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latches).
   always_comb begin
      bus.gene_rd_en = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;
      bus.node_sel0  = sel0_q;
      bus.node_sel1  = sel1_q;
      bus.node_func  = func_q;
      case (state_q)
         S_FETCH: begin
            bus.gene_rd_en = 1'b1;
            busy           = 1'b1;
         end
         S_EVAL: begin
            busy          = 1'b1;
            bus.node_sel0 = gene_sel0;
            bus.node_sel1 = gene_sel1;
            bus.node_func = gene_func;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      k_d       = k_q;
      in_d      = in_q;
      values_d  = values_q;
      fwd_err_d = fwd_err_q;
      sel0_d    = sel0_q;
      sel1_d    = sel1_q;
      func_d    = func_q;
      if (accept) begin
         k_d       = '0;
         in_d      = in_bits;
         values_d  = '0;
         fwd_err_d = 1'b0;
      end
      if (state_q == S_EVAL) begin
         values_d[k_q] = bus.node_result;
         // A select at or above NUM_IN+k points at the current node or a later one.
         if (({1'b0, gene_sel0} >= fwd_limit) || ({1'b0, gene_sel1} >= fwd_limit)) begin
            fwd_err_d = 1'b1;
         end
         sel0_d = gene_sel0;
         sel1_d = gene_sel1;
         func_d = gene_func;
         if (!last_node) k_d = k_q + ADDR_BIT'(1);
      end
   end

   // NOTE: values is a small register vector rather than a RAM, so it takes the reset like any flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         k_q       <= '0;
         in_q      <= '0;
         values_q  <= '0;
         fwd_err_q <= 1'b0;
         sel0_q    <= '0;
         sel1_q    <= '0;
         func_q    <= '0;
      end else begin
         k_q       <= k_d;
         in_q      <= in_d;
         values_q  <= values_d;
         fwd_err_q <= fwd_err_d;
         sel0_q    <= sel0_d;
         sel1_q    <= sel1_d;
         func_q    <= func_d;
      end
   end

   assign bus.gene_addr    = k_q;
   assign bus.node_choices = CHOICES_BIT'({values_q, in_q});
   assign values           = values_q;
   assign result           = values_q[NUM_NODES-1];
   assign fwd_err          = fwd_err_q;

endmodule

// File: tb/tb_cgp_node_sequencer.sv
// Bench for cgp_node_sequencer: models the genome memory and node block, and compares each run
// against a reference evaluation of the genome.
module tb_cgp_node_sequencer;
   localparam int NUM_IN    = 4;
   localparam int NUM_NODES = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] in_bits;
   logic       busy, done, result, fwd_err;
   logic [4:0] values;

   logic [9:0] gene_mem [8];
   int         n_cmp = 0;
   int         n_err = 0;

   cgp_node_sequencer_if bus ();

   cgp_node_sequencer dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .in_bits(in_bits),
      .bus    (bus),
      .busy   (busy),
      .done   (done),
      .result (result),
      .values (values),
      .fwd_err(fwd_err)
   );

   always #5 clk = ~clk;

   function automatic logic pick(input logic [8:0] c, input logic [3:0] s);
      logic [15:0] ext;
      ext = {7'b0, c};
      return ext[s];
   endfunction

   function automatic logic fn(input logic [1:0] f, input logic a, input logic b);
      case (f)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   // Node block: out-of-range selects read 0.
   always_comb begin
      logic a, b;
      a = pick(bus.node_choices, bus.node_sel0);
      b = pick(bus.node_choices, bus.node_sel1);
      bus.node_result = fn(bus.node_func, a, b);
   end

   always @(posedge clk) begin
      if (bus.gene_rd_en) bus.gene_data <= gene_mem[bus.gene_addr];
   end

   function automatic logic [9:0] gene(input int f, input int s1, input int s0);
      return {2'(f), 4'(s1), 4'(s0)};
   endfunction

   // Reference: nodes in order, unevaluated nodes read 0, select at/after own slot flags fwd_err.
   task automatic ref_eval(input logic [3:0] inb, output logic [4:0] vals, output logic ferr);
      logic [8:0] ch;
      int s0, s1;
      vals = '0;
      ferr = 1'b0;
      for (int k = 0; k < NUM_NODES; k++) begin
         ch = {vals, inb};
         s0 = int'(gene_mem[k][3:0]);
         s1 = int'(gene_mem[k][7:4]);
         if (s0 >= NUM_IN + k || s1 >= NUM_IN + k) ferr = 1'b1;
         vals[k] = fn(gene_mem[k][9:8], pick(ch, 4'(s0)), pick(ch, 4'(s1)));
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_check(input string tag, input int n);
      bit quiet;
      quiet = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (busy || done || bus.gene_rd_en) quiet = 1'b0;
      end
      check(tag, 32'(quiet), 32'd1);
   endtask

   task automatic run_eval(input string tag, input logic [3:0] inb, input bit hold_start,
                           input bit poke_start);
      logic [4:0] exp_vals;
      logic       exp_ferr;
      int         cyc;
      bit         seen;
      ref_eval(inb, exp_vals, exp_ferr);
      @(negedge clk);
      check({tag, "_pre_done"}, 32'(done), 32'd0);
      in_bits = inb;
      start   = 1'b1;
      @(posedge clk);
      cyc  = 0;
      seen = 1'b0;
      while (cyc < 40 && !seen) begin
         @(negedge clk);
         cyc++;
         if (!hold_start) start = 1'b0;
         if (cyc == 1) begin
            check({tag, "_clr_values"}, 32'(values), 32'd0);
            check({tag, "_clr_fwd"}, 32'(fwd_err), 32'd0);
            check({tag, "_busy"}, 32'(busy), 32'd1);
         end
         if (cyc <= 2 * NUM_NODES) begin
            if (cyc % 2 == 1) begin
               check({tag, "_rd_en"}, 32'(bus.gene_rd_en), 32'd1);
               check({tag, "_addr"}, 32'(bus.gene_addr), 32'((cyc - 1) / 2));
            end else begin
               check({tag, "_rd_idle"}, 32'(bus.gene_rd_en), 32'd0);
               check({tag, "_gene_out"}, 32'({bus.node_func, bus.node_sel1, bus.node_sel0}),
                     32'(gene_mem[cyc/2-1]));
            end
         end
         if (poke_start && cyc == 3) begin
            start   = 1'b1;
            in_bits = ~inb;
         end
         if (done) seen = 1'b1;
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, 32'(cyc), 32'(2 * NUM_NODES + 1));
      check({tag, "_values"}, 32'(values), 32'(exp_vals));
      check({tag, "_result"}, 32'(result), 32'(exp_vals[4]));
      check({tag, "_fwd_err"}, 32'(fwd_err), 32'(exp_ferr));
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      if (!hold_start) begin
         @(negedge clk);
         check({tag, "_done_pulse"}, 32'(done), 32'd0);
         check({tag, "_hold_values"}, 32'(values), 32'(exp_vals));
      end
   endtask

   task automatic load_random();
      for (int k = 0; k < NUM_NODES; k++) begin
         logic [3:0] s0, s1;
         if ($urandom_range(0, 3) != 0) begin
            s0 = 4'($urandom_range(0, NUM_IN + k - 1));
            s1 = 4'($urandom_range(0, NUM_IN + k - 1));
         end else begin
            s0 = 4'($urandom_range(0, 15));
            s1 = 4'($urandom_range(0, 15));
         end
         gene_mem[k] = {2'($urandom_range(0, 3)), s1, s0};
      end
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      in_bits = '0;
      for (int i = 0; i < 8; i++) gene_mem[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_values", 32'(values), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_fwd", 32'(fwd_err), 32'd0);
      check("rst_rd_en", 32'(bus.gene_rd_en), 32'd0);
      check("rst_sel", 32'({bus.node_func, bus.node_sel1, bus.node_sel0}), 32'd0);
      rst = 1'b0;

      // T2: AND chain over inputs 0 and 1
      for (int k = 0; k < NUM_NODES; k++) gene_mem[k] = gene(0, 1, 0);
      run_eval("chain", 4'b0011, 1'b0, 1'b0);
      check("chain_all_ones", 32'(values), 32'h1f);

      // T1: reset for two cycles while node 1 is evaluating
      gene_mem[0] = gene(1, 0, 7);
      @(negedge clk);
      in_bits = 4'b0001;
      start   = 1'b1;
      @(posedge clk);
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("t1_pre_values", 32'(values), 32'd1);
      check("t1_pre_fwd", 32'(fwd_err), 32'd1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("t1_busy", 32'(busy), 32'd0);
      check("t1_done", 32'(done), 32'd0);
      check("t1_values", 32'(values), 32'd0);
      check("t1_fwd", 32'(fwd_err), 32'd0);
      idle_check("t1_idle", 6);

      // T3: node 1 selects itself
      for (int k = 0; k < NUM_NODES; k++) gene_mem[k] = gene(0, 1, 0);
      gene_mem[1] = gene(0, 1, 5);
      run_eval("fwd", 4'b1111, 1'b0, 1'b0);
      check("fwd_node1_zero", 32'(values[1]), 32'd0);
      idle_check("fwd_idle", 4);
      check("fwd_sticky", 32'(fwd_err), 32'd1);
      gene_mem[1] = gene(2, 0, 4);
      run_eval("fwd_clean", 4'b0101, 1'b0, 1'b0);

      // T4: start pulse mid-run is ignored
      load_random();
      run_eval("poke", 4'b1010, 1'b0, 1'b1);
      idle_check("poke_no_rerun", 15);

      // T5: start held high gives back-to-back runs
      load_random();
      gene_mem[0] = gene(1, 0, 1);
      run_eval("b2b_a", 4'b0011, 1'b1, 1'b0);
      run_eval("b2b_b", 4'b1100, 1'b0, 1'b0);

      // Randomized genomes and inputs
      for (int r = 0; r < 12; r++) begin
         load_random();
         run_eval("rand", 4'($urandom_range(0, 15)), 1'b0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
